// File: rtl/ks10_bus_arb_if.sv
// Signal bundle between the KS10 backplane arbiter, its three requesting
// masters (CPU, console, UBA DMA) and the memory/IO slave side.
interface ks10_bus_arb_if;
   logic        cpuREQI;
   logic [35:0] cpuADDRI;
   logic [35:0] cpuDATAI;
   logic        cpuACKO;
   logic        cslREQI;
   logic [35:0] cslADDRI;
   logic [35:0] cslDATAI;
   logic        cslACKO;
   logic        ubaREQI;
   logic [35:0] ubaADDRI;
   logic [35:0] ubaDATAI;
   logic        ubaACKO;
   logic        arbREQO;
   logic [35:0] arbADDRO;
   logic [35:0] arbDATAO;
   logic        arbACKI;
   logic [35:0] arbDATAI;
   logic [35:0] arbDATAR;
   logic [2:0]  arbGNT;
   logic        arbTIMEOUT;

   // Arbiter side of the bundle.
   modport slave (
      input  cpuREQI, cpuADDRI, cpuDATAI,
      input  cslREQI, cslADDRI, cslDATAI,
      input  ubaREQI, ubaADDRI, ubaDATAI,
      input  arbACKI, arbDATAI,
      output cpuACKO, cslACKO, ubaACKO,
      output arbREQO, arbADDRO, arbDATAO, arbDATAR, arbGNT, arbTIMEOUT
   );

   // Environment side: requesting masters plus the responding slave.
   modport master (
      output cpuREQI, cpuADDRI, cpuDATAI,
      output cslREQI, cslADDRI, cslDATAI,
      output ubaREQI, ubaADDRI, ubaDATAI,
      output arbACKI, arbDATAI,
      input  cpuACKO, cslACKO, ubaACKO,
      input  arbREQO, arbADDRO, arbDATAO, arbDATAR, arbGNT, arbTIMEOUT
   );
endinterface

// File: rtl/ks10_bus_arb.sv
// KS10 backplane arbiter: round-robin grant among CPU, UBA and console,
// forwards the granted cycle to the slaves and times out unanswered cycles.
module ks10_bus_arb #(
   parameter int unsigned TIMEOUT = 127,
   parameter int unsigned CNTW    = 7
) (
   input logic           clk,
   input logic           rst,
   ks10_bus_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {M_CPU, M_UBA, M_CSL} master_t;

   state_t          state, stateNxt;
   master_t         last, lastNxt;
   logic [CNTW-1:0] cnt, cntNxt;
   logic            reqR, reqNxt;
   logic [2:0]      gntR, gntNxt;
   logic [2:0]      ackR, ackNxt;
   logic            tmoR, tmoNxt;
   logic [35:0]     addrR, addrNxt;
   logic [35:0]     dataR, dataNxt;
   logic [35:0]     datarR, datarNxt;
   logic [2:0]      reqVec;
   logic [2:0]      winOh;
   logic            grantedReq;

   // Bit positions match arbGNT: {csl,uba,cpu}.
   assign reqVec     = {bus.cslREQI, bus.ubaREQI, bus.cpuREQI};
   assign grantedReq = |(reqVec & gntR);

   // The master following the last granted one has highest priority.
   always_comb begin
      winOh = '0;
      case (last)
         M_CPU:   winOh = reqVec[1] ? 3'b010 : reqVec[2] ? 3'b100 :
                          reqVec[0] ? 3'b001 : 3'b000;
         M_UBA:   winOh = reqVec[2] ? 3'b100 : reqVec[0] ? 3'b001 :
                          reqVec[1] ? 3'b010 : 3'b000;
         default: winOh = reqVec[0] ? 3'b001 : reqVec[1] ? 3'b010 :
                          reqVec[2] ? 3'b100 : 3'b000;
      endcase
   end

   always_comb begin
      stateNxt = state;
      lastNxt  = last;
      cntNxt   = cnt;
      reqNxt   = reqR;
      gntNxt   = gntR;
      ackNxt   = '0;
      tmoNxt   = 1'b0;
      addrNxt  = addrR;
      dataNxt  = dataR;
      datarNxt = datarR;
      case (state)
         IDLE: begin
            if (|winOh) begin
               gntNxt   = winOh;
               reqNxt   = 1'b1;
               cntNxt   = '0;
               stateNxt = BUSY;
               case (winOh)
                  3'b001: begin
                     addrNxt = bus.cpuADDRI;
                     dataNxt = bus.cpuDATAI;
                  end
                  3'b010: begin
                     addrNxt = bus.ubaADDRI;
                     dataNxt = bus.ubaDATAI;
                  end
                  default: begin
                     addrNxt = bus.cslADDRI;
                     dataNxt = bus.cslDATAI;
                  end
               endcase
            end
         end
         BUSY: begin
            cntNxt = cnt + 1'b1;
            // A slave ack takes precedence over a coincident timeout.
            if (bus.arbACKI) begin
               datarNxt = bus.arbDATAI;
               ackNxt   = gntR;
               reqNxt   = 1'b0;
               stateNxt = DONE;
            end else if (cnt == CNTW'(TIMEOUT)) begin
               datarNxt = '0;
               ackNxt   = gntR;
               tmoNxt   = 1'b1;
               reqNxt   = 1'b0;
               stateNxt = DONE;
            end
         end
         DONE: begin
            if (!grantedReq) begin
               gntNxt   = '0;
               lastNxt  = gntR[0] ? M_CPU : gntR[1] ? M_UBA : M_CSL;
               stateNxt = IDLE;
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         last   <= M_CSL;
         cnt    <= '0;
         reqR   <= 1'b0;
         gntR   <= '0;
         ackR   <= '0;
         tmoR   <= 1'b0;
         addrR  <= '0;
         dataR  <= '0;
         datarR <= '0;
      end else begin
         state  <= stateNxt;
         last   <= lastNxt;
         cnt    <= cntNxt;
         reqR   <= reqNxt;
         gntR   <= gntNxt;
         ackR   <= ackNxt;
         tmoR   <= tmoNxt;
         addrR  <= addrNxt;
         dataR  <= dataNxt;
         datarR <= datarNxt;
      end
   end

   assign bus.cpuACKO    = ackR[0];
   assign bus.ubaACKO    = ackR[1];
   assign bus.cslACKO    = ackR[2];
   assign bus.arbREQO    = reqR;
   assign bus.arbADDRO   = addrR;
   assign bus.arbDATAO   = dataR;
   assign bus.arbDATAR   = datarR;
   assign bus.arbGNT     = gntR;
   assign bus.arbTIMEOUT = tmoR;

endmodule

// File: tb/tb_ks10_bus_arb.sv
// Directed bench for ks10_bus_arb: a per-cycle vector table for the
// basic transfers plus hand-written timeout, race, reset and stability runs.
module tb_ks10_bus_arb;

   localparam int unsigned TMO = 127;

   localparam logic [35:0] CPU_A  = 36'o000000001000;
   localparam logic [35:0] UBA_A  = 36'o000000002000;
   localparam logic [35:0] CSL_A  = 36'o000000003000;
   localparam logic [35:0] CPU_D  = 36'o111111111111;
   localparam logic [35:0] UBA_D  = 36'o222222222222;
   localparam logic [35:0] CSL_D  = 36'o333333333333;
   localparam logic [35:0] R1     = 36'o123456701234;
   localparam logic [35:0] A1     = 36'o000000000011;
   localparam logic [35:0] A2     = 36'o000000000022;
   localparam logic [35:0] A3     = 36'o000000000033;
   localparam logic [35:0] A4     = 36'o000000000044;
   localparam logic [35:0] A5     = 36'o555555555555;
   localparam logic [35:0] RACE_D = 36'o765432107654;
   localparam logic [35:0] STAB_D = 36'o246024602460;
   localparam logic [35:0] Z      = 36'o0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ks10_bus_arb_if bus ();

   ks10_bus_arb #(.TIMEOUT(TMO), .CNTW(7)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        rst, cpu, uba, csl, ack;
      logic [35:0] din;
      logic        expReq;
      logic [2:0]  expGnt;
      logic [2:0]  expAck;
      logic        expTmo;
      logic [35:0] expDatr, expAddr, expDatO;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic r, c, u, s, a, input logic [35:0] din,
                               input logic eReq, input logic [2:0] eGnt, eAck,
                               input logic eTmo, input logic [35:0] eDatr, eAddr, eDatO);
      vec_t v;
      v.rst = r; v.cpu = c; v.uba = u; v.csl = s; v.ack = a; v.din = din;
      v.expReq = eReq; v.expGnt = eGnt; v.expAck = eAck; v.expTmo = eTmo;
      v.expDatr = eDatr; v.expAddr = eAddr; v.expDatO = eDatO;
      return v;
   endfunction

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
      end
   endtask

   task automatic chkOut(input string tag, input logic req, input logic [2:0] gnt,
                         input logic [2:0] ack, input logic tmo, input logic [35:0] datr);
      chk({tag, ".arbREQO"},    36'(bus.arbREQO), 36'(req));
      chk({tag, ".arbGNT"},     36'(bus.arbGNT), 36'(gnt));
      chk({tag, ".ACKO"},       36'({bus.cslACKO, bus.ubaACKO, bus.cpuACKO}), 36'(ack));
      chk({tag, ".arbTIMEOUT"}, 36'(bus.arbTIMEOUT), 36'(tmo));
      chk({tag, ".arbDATAR"},   bus.arbDATAR, datr);
   endtask

   task automatic drive(input logic r, c, u, s, a, input logic [35:0] din);
      rst          = r;
      bus.cpuREQI  = c;
      bus.ubaREQI  = u;
      bus.cslREQI  = s;
      bus.arbACKI  = a;
      bus.arbDATAI = din;
   endtask

   initial begin
      bus.cpuADDRI = CPU_A; bus.cpuDATAI = CPU_D;
      bus.ubaADDRI = UBA_A; bus.ubaDATAI = UBA_D;
      bus.cslADDRI = CSL_A; bus.cslDATAI = CSL_D;
      drive(1, 0, 0, 0, 0, Z);
      repeat (2) @(posedge clk);

      //               rst cpu uba csl ack din   req gnt     ack     tmo datr addr   datO
      tbl.push_back(mk(1, 0, 0, 0, 0, Z,   0, 3'b000, 3'b000, 0, Z,  Z,     Z));
      tbl.push_back(mk(0, 1, 0, 0, 0, Z,   0, 3'b000, 3'b000, 0, Z,  Z,     Z));
      tbl.push_back(mk(0, 1, 0, 0, 0, Z,   1, 3'b001, 3'b000, 0, Z,  CPU_A, CPU_D));
      tbl.push_back(mk(0, 1, 0, 0, 0, Z,   1, 3'b001, 3'b000, 0, Z,  CPU_A, CPU_D));
      tbl.push_back(mk(0, 1, 0, 0, 1, R1,  1, 3'b001, 3'b000, 0, Z,  CPU_A, CPU_D));
      tbl.push_back(mk(0, 1, 0, 0, 0, Z,   0, 3'b001, 3'b001, 0, R1, CPU_A, CPU_D));
      tbl.push_back(mk(0, 0, 0, 0, 0, Z,   0, 3'b001, 3'b000, 0, R1, CPU_A, CPU_D));
      tbl.push_back(mk(0, 0, 0, 0, 0, Z,   0, 3'b000, 3'b000, 0, R1, CPU_A, CPU_D));
      tbl.push_back(mk(1, 0, 0, 0, 0, Z,   0, 3'b000, 3'b000, 0, R1, CPU_A, CPU_D));
      tbl.push_back(mk(0, 1, 1, 1, 0, Z,   0, 3'b000, 3'b000, 0, Z,  Z,     Z));
      tbl.push_back(mk(0, 1, 1, 1, 1, A1,  1, 3'b001, 3'b000, 0, Z,  CPU_A, CPU_D));
      tbl.push_back(mk(0, 1, 1, 1, 0, Z,   0, 3'b001, 3'b001, 0, A1, CPU_A, CPU_D));
      tbl.push_back(mk(0, 0, 1, 1, 0, Z,   0, 3'b001, 3'b000, 0, A1, CPU_A, CPU_D));
      tbl.push_back(mk(0, 0, 1, 1, 0, Z,   0, 3'b000, 3'b000, 0, A1, CPU_A, CPU_D));
      tbl.push_back(mk(0, 0, 1, 1, 1, A2,  1, 3'b010, 3'b000, 0, A1, UBA_A, UBA_D));
      tbl.push_back(mk(0, 0, 1, 1, 0, Z,   0, 3'b010, 3'b010, 0, A2, UBA_A, UBA_D));
      tbl.push_back(mk(0, 0, 0, 1, 0, Z,   0, 3'b010, 3'b000, 0, A2, UBA_A, UBA_D));
      tbl.push_back(mk(0, 0, 0, 1, 0, Z,   0, 3'b000, 3'b000, 0, A2, UBA_A, UBA_D));
      tbl.push_back(mk(0, 0, 0, 1, 1, A3,  1, 3'b100, 3'b000, 0, A2, CSL_A, CSL_D));
      tbl.push_back(mk(0, 0, 0, 1, 0, Z,   0, 3'b100, 3'b100, 0, A3, CSL_A, CSL_D));
      tbl.push_back(mk(0, 0, 0, 0, 0, Z,   0, 3'b100, 3'b000, 0, A3, CSL_A, CSL_D));
      tbl.push_back(mk(0, 0, 0, 0, 1, A5,  0, 3'b000, 3'b000, 0, A3, CSL_A, CSL_D));
      tbl.push_back(mk(0, 0, 0, 0, 0, Z,   0, 3'b000, 3'b000, 0, A3, CSL_A, CSL_D));
      tbl.push_back(mk(0, 1, 0, 0, 0, Z,   0, 3'b000, 3'b000, 0, A3, CSL_A, CSL_D));
      tbl.push_back(mk(0, 0, 0, 0, 0, Z,   1, 3'b001, 3'b000, 0, A3, CPU_A, CPU_D));
      tbl.push_back(mk(0, 0, 0, 0, 1, A4,  1, 3'b001, 3'b000, 0, A3, CPU_A, CPU_D));
      tbl.push_back(mk(0, 0, 0, 0, 1, A5,  0, 3'b001, 3'b001, 0, A4, CPU_A, CPU_D));
      tbl.push_back(mk(0, 0, 0, 0, 0, Z,   0, 3'b000, 3'b000, 0, A4, CPU_A, CPU_D));

      // Each row: check this cycle's outputs, then drive this cycle's inputs.
      foreach (tbl[i]) begin
         @(negedge clk);
         chkOut($sformatf("row%0d", i), tbl[i].expReq, tbl[i].expGnt, tbl[i].expAck,
                tbl[i].expTmo, tbl[i].expDatr);
         chk($sformatf("row%0d.arbADDRO", i), bus.arbADDRO, tbl[i].expAddr);
         chk($sformatf("row%0d.arbDATAO", i), bus.arbDATAO, tbl[i].expDatO);
         drive(tbl[i].rst, tbl[i].cpu, tbl[i].uba, tbl[i].csl, tbl[i].ack, tbl[i].din);
      end

      // Timeout: UBA cycle with no slave ack.
      @(negedge clk);
      drive(0, 0, 1, 0, 0, Z);
      @(negedge clk);
      chkOut("tmo.start", 1, 3'b010, 3'b000, 0, A4);
      chk("tmo.arbADDRO", bus.arbADDRO, UBA_A);
      for (int i = 1; i <= int'(TMO); i++) begin
         @(negedge clk);
         chk($sformatf("tmo.wait%0d", i),
             36'({bus.arbREQO, bus.arbTIMEOUT, bus.ubaACKO}), 36'(3'b100));
      end
      @(negedge clk);
      chkOut("tmo.fire", 0, 3'b010, 3'b010, 1, Z);
      drive(0, 0, 0, 0, 0, Z);
      @(negedge clk);
      chkOut("tmo.after", 0, 3'b000, 3'b000, 0, Z);

      // Race: ack lands in the cycle the counter reaches TIMEOUT.
      drive(0, 1, 0, 0, 0, Z);
      @(negedge clk);
      chkOut("race.start", 1, 3'b001, 3'b000, 0, Z);
      for (int i = 1; i < int'(TMO); i++) begin
         @(negedge clk);
         chk($sformatf("race.wait%0d", i),
             36'({bus.arbREQO, bus.arbTIMEOUT, bus.cpuACKO}), 36'(3'b100));
      end
      @(negedge clk);
      chk("race.edge.arbREQO", 36'(bus.arbREQO), 36'(1'b1));
      drive(0, 1, 0, 0, 1, RACE_D);
      @(negedge clk);
      chkOut("race.ack", 0, 3'b001, 3'b001, 0, RACE_D);
      drive(0, 0, 0, 0, 0, Z);
      @(negedge clk);
      chkOut("race.after", 0, 3'b000, 3'b000, 0, RACE_D);

      // Reset during a console BUSY cycle, with a coincident slave ack.
      drive(0, 0, 0, 1, 0, Z);
      @(negedge clk);
      chkOut("rst.busy", 1, 3'b100, 3'b000, 0, RACE_D);
      chk("rst.busy.arbADDRO", bus.arbADDRO, CSL_A);
      drive(1, 0, 0, 1, 1, A5);
      @(negedge clk);
      chkOut("rst.clear", 0, 3'b000, 3'b000, 0, Z);
      chk("rst.clear.arbADDRO", bus.arbADDRO, Z);
      chk("rst.clear.arbDATAO", bus.arbDATAO, Z);
      drive(0, 1, 0, 1, 0, Z);
      @(negedge clk);
      chkOut("rst.cpuFirst", 1, 3'b001, 3'b000, 0, Z);
      chk("rst.cpuFirst.arbADDRO", bus.arbADDRO, CPU_A);

      // Stability: console address/data churn while the CPU cycle is BUSY.
      for (int i = 0; i < 4; i++) begin
         bus.cslADDRI = 36'({$urandom(), $urandom()});
         bus.cslDATAI = 36'({$urandom(), $urandom()});
         @(negedge clk);
         chk($sformatf("stab%0d.arbADDRO", i), bus.arbADDRO, CPU_A);
         chk($sformatf("stab%0d.arbDATAO", i), bus.arbDATAO, CPU_D);
         chk($sformatf("stab%0d.arbGNT", i), 36'(bus.arbGNT), 36'(3'b001));
         chk($sformatf("stab%0d.arbREQO", i), 36'(bus.arbREQO), 36'(1'b1));
      end
      drive(0, 1, 0, 1, 1, STAB_D);
      @(negedge clk);
      chkOut("stab.ack", 0, 3'b001, 3'b001, 0, STAB_D);
      drive(0, 0, 0, 0, 0, Z);
      bus.cslADDRI = CSL_A;
      bus.cslDATAI = CSL_D;
      @(negedge clk);
      chkOut("stab.idle", 0, 3'b000, 3'b000, 0, STAB_D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
